// File: rtl/tiger_mem_arbiter.sv
// Shares the Tiger core's single Avalon-MM master between the icache and dcache miss engines.
// Define TIGER_ARB_FAIRNESS_EN to stop a stream of data misses from starving the icache.
module tiger_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_W    = 4,
    parameter int FAIR_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    input  logic [BURST_W-1:0] i_burstcount,
    output logic               i_waitrequest,
    output logic [DATA_W-1:0]  i_readdata,
    output logic               i_readdatavalid,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BURST_W-1:0] d_burstcount,
    input  logic [DATA_W-1:0]  d_writedata,
    output logic               d_waitrequest,
    output logic [DATA_W-1:0]  d_readdata,
    output logic               d_readdatavalid,
    output logic               m_read,
    output logic               m_write,
    output logic [ADDR_W-1:0]  m_address,
    output logic [BURST_W-1:0] m_burstcount,
    output logic [DATA_W-1:0]  m_writedata,
    input  logic [DATA_W-1:0]  m_readdata,
    input  logic               m_readdatavalid,
    input  logic               m_waitrequest,
    output logic               gnt_i,
    output logic               gnt_d
);

    typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;

    state_t             stateReg, stateNext;
    logic [BURST_W-1:0] beatCntReg, beatCntNext;
    logic               acceptedReg, acceptedNext;
    logic               dReq;
    logic               pickI;
    logic               ownerRead;
    logic [BURST_W-1:0] ownerBurst;

    // A zero burstcount still moves one beat.
    function automatic logic [BURST_W-1:0] normBurst(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

    assign dReq = d_read | d_write;

`ifdef TIGER_ARB_FAIRNESS_EN
    localparam int FAIR_W = ($clog2(FAIR_LIMIT + 1) > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
    logic [FAIR_W-1:0] fairCntReg;
    logic              fairBump;
    logic              fairClear;

    assign pickI     = i_read && (!dReq || fairCntReg == FAIR_W'(FAIR_LIMIT));
    assign fairBump  = (stateReg == IDLE) && !pickI && dReq && i_read;
    assign fairClear = (stateReg == IDLE) && (pickI || !i_read);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fairCntReg <= '0;
        end else if (fairClear) begin
            fairCntReg <= '0;
        end else if (fairBump) begin
            fairCntReg <= fairCntReg + FAIR_W'(1);
        end
    end
`else
    assign pickI = i_read && !dReq;
`endif

    assign ownerRead  = (stateReg == I_RD) ? i_read : d_read;
    assign ownerBurst = (stateReg == I_RD) ? i_burstcount : d_burstcount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg    <= IDLE;
            beatCntReg  <= '0;
            acceptedReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            beatCntReg  <= beatCntNext;
            acceptedReg <= acceptedNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        beatCntNext  = beatCntReg;
        acceptedNext = acceptedReg;
        case (stateReg)
            IDLE: begin
                acceptedNext = 1'b0;
                if (pickI) begin
                    stateNext = I_RD;
                end else if (d_write) begin
                    stateNext   = D_WR;
                    beatCntNext = normBurst(d_burstcount);
                end else if (d_read) begin
                    stateNext = D_RD;
                end
            end
            I_RD, D_RD: begin
                if (!acceptedReg) begin
                    if (ownerRead && !m_waitrequest) begin
                        acceptedNext = 1'b1;
                        beatCntNext  = normBurst(ownerBurst);
                    end
                end else if (m_readdatavalid) begin
                    beatCntNext = beatCntReg - BURST_W'(1);
                    if (beatCntReg == BURST_W'(1)) begin
                        stateNext = IDLE;
                    end
                end
            end
            D_WR: begin
                if (d_write && !m_waitrequest) begin
                    beatCntNext = beatCntReg - BURST_W'(1);
                    if (beatCntReg == BURST_W'(1)) begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Once a read command is accepted the owner is held off, so a held request
    // is not mistaken for a second accepted command.
    always_comb begin
        m_read          = 1'b0;
        m_write         = 1'b0;
        m_address       = '0;
        m_burstcount    = '0;
        m_writedata     = '0;
        i_waitrequest   = 1'b1;
        d_waitrequest   = 1'b1;
        i_readdata      = '0;
        d_readdata      = '0;
        i_readdatavalid = 1'b0;
        d_readdatavalid = 1'b0;
        gnt_i           = 1'b0;
        gnt_d           = 1'b0;
        case (stateReg)
            I_RD: begin
                gnt_i           = 1'b1;
                m_read          = i_read && !acceptedReg;
                m_address       = i_address;
                m_burstcount    = i_burstcount;
                i_waitrequest   = acceptedReg | m_waitrequest;
                i_readdata      = m_readdata;
                i_readdatavalid = acceptedReg & m_readdatavalid;
            end
            D_RD: begin
                gnt_d           = 1'b1;
                m_read          = d_read && !acceptedReg;
                m_address       = d_address;
                m_burstcount    = d_burstcount;
                d_waitrequest   = acceptedReg | m_waitrequest;
                d_readdata      = m_readdata;
                d_readdatavalid = acceptedReg & m_readdatavalid;
            end
            D_WR: begin
                gnt_d         = 1'b1;
                m_write       = d_write;
                m_address     = d_address;
                m_burstcount  = d_burstcount;
                m_writedata   = d_writedata;
                d_waitrequest = m_waitrequest;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tiger_mem_arbiter.sv
// Directed self-checking bench for tiger_mem_arbiter: reset, icache/dcache bursts,
// priority, write burst under backpressure, fairness, zero burstcount, mid-burst reset.
module tb_tiger_mem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BURST_W    = 4;
    localparam int FAIR_LIMIT = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               i_read;
    logic [ADDR_W-1:0]  i_address;
    logic [BURST_W-1:0] i_burstcount;
    logic               i_waitrequest;
    logic [DATA_W-1:0]  i_readdata;
    logic               i_readdatavalid;
    logic               d_read;
    logic               d_write;
    logic [ADDR_W-1:0]  d_address;
    logic [BURST_W-1:0] d_burstcount;
    logic [DATA_W-1:0]  d_writedata;
    logic               d_waitrequest;
    logic [DATA_W-1:0]  d_readdata;
    logic               d_readdatavalid;
    logic               m_read;
    logic               m_write;
    logic [ADDR_W-1:0]  m_address;
    logic [BURST_W-1:0] m_burstcount;
    logic [DATA_W-1:0]  m_writedata;
    logic [DATA_W-1:0]  m_readdata;
    logic               m_readdatavalid;
    logic               m_waitrequest;
    logic               gnt_i;
    logic               gnt_d;

    int nTests = 0;
    int nFail  = 0;

    tiger_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .FAIR_LIMIT(FAIR_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address), .i_burstcount(i_burstcount),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_burstcount(d_burstcount),
        .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .d_readdatavalid(d_readdatavalid),
        .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_burstcount(m_burstcount),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_waitrequest(m_waitrequest), .gnt_i(gnt_i), .gnt_d(gnt_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int cyc;
        logic expD;

        reset_n = 1'b0;
        i_read = 1'b1; i_address = 32'h1234; i_burstcount = 4'd3;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h5678; d_burstcount = 4'd2;
        d_writedata = 32'h9ABC;
        m_readdata = 32'hDEAD; m_readdatavalid = 1'b1; m_waitrequest = 1'b0;

        // Reset values with requests and stray beats present
        tick(); tick();
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_gnt_i", gnt_i, 0);
        chk("rst_gnt_d", gnt_d, 0);
        chk("rst_i_rdv", i_readdatavalid, 0);
        chk("rst_d_rdv", d_readdatavalid, 0);
        chk("rst_i_wait", i_waitrequest, 1);
        chk("rst_d_wait", d_waitrequest, 1);
        chk("rst_m_addr", m_address, 0);
        chk("rst_m_bc", m_burstcount, 0);
        chk("rst_m_wdata", m_writedata, 0);
        chk("rst_i_rdata", i_readdata, 0);
        chk("rst_d_rdata", d_readdata, 0);
        $display("[TB] reset values checked");

        i_read = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Lone icache read, burst 4, two cycles of memory waitrequest
        i_read = 1'b1; i_address = 32'h1000; i_burstcount = 4'd4; m_waitrequest = 1'b1;
        settle();
        chk("t1_idle_m_read", m_read, 0);
        chk("t1_idle_i_wait", i_waitrequest, 1);
        tick();
        chk("t1_c1_gnt_i", gnt_i, 1);
        chk("t1_c1_m_read", m_read, 1);
        chk("t1_c1_m_addr", m_address, 32'h1000);
        chk("t1_c1_m_bc", m_burstcount, 4);
        chk("t1_c1_i_wait", i_waitrequest, 1);
        tick();
        chk("t1_c2_m_read", m_read, 1);
        m_waitrequest = 1'b0;
        settle();
        chk("t1_c3_i_wait", i_waitrequest, 0);
        tick();
        i_read = 1'b0;
        settle();
        chk("t1_post_acc_m_read", m_read, 0);
        chk("t1_post_acc_gnt_i", gnt_i, 1);
        for (int k = 0; k < 4; k++) begin
            m_readdatavalid = 1'b1; m_readdata = 32'hA000 + k;
            settle();
            chk("t1_i_rdv", i_readdatavalid, 1);
            chk("t1_i_rdata", i_readdata, 32'hA000 + k);
            chk("t1_d_rdv", d_readdatavalid, 0);
            tick();
            m_readdatavalid = 1'b0;
            if (k == 1) begin
                settle();
                chk("t1_gap_gnt_i", gnt_i, 1);
                chk("t1_gap_i_rdv", i_readdatavalid, 0);
                tick();
            end
        end
        settle();
        chk("t1_end_gnt_i", gnt_i, 0);
        chk("t1_end_i_wait", i_waitrequest, 1);
        $display("[TB] icache burst of 4 done");

        // Simultaneous requests: dcache first, icache one cycle after its last beat
        i_read = 1'b1; i_address = 32'h2000; i_burstcount = 4'd1;
        d_read = 1'b1; d_address = 32'h3000; d_burstcount = 4'd2;
        m_waitrequest = 1'b0;
        tick();
        chk("t2_gnt_d", gnt_d, 1);
        chk("t2_gnt_i", gnt_i, 0);
        chk("t2_m_addr", m_address, 32'h3000);
        chk("t2_m_read", m_read, 1);
        chk("t2_i_wait", i_waitrequest, 1);
        chk("t2_d_wait", d_waitrequest, 0);
        tick();
        d_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_readdatavalid = 1'b1; m_readdata = 32'hB000 + k;
            settle();
            chk("t2_d_rdv", d_readdatavalid, 1);
            chk("t2_d_rdata", d_readdata, 32'hB000 + k);
            chk("t2_i_rdv", i_readdatavalid, 0);
            chk("t2_i_wait_hold", i_waitrequest, 1);
            tick();
            m_readdatavalid = 1'b0;
        end
        settle();
        chk("t2_idle_gnt_d", gnt_d, 0);
        chk("t2_idle_gnt_i", gnt_i, 0);
        chk("t2_idle_i_wait", i_waitrequest, 1);
        tick();
        chk("t2_i_gnt", gnt_i, 1);
        chk("t2_i_addr", m_address, 32'h2000);
        tick();
        i_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hC000;
        settle();
        chk("t2_i_beat", i_readdatavalid, 1);
        chk("t2_i_beat_data", i_readdata, 32'hC000);
        tick();
        m_readdatavalid = 1'b0;
        settle();
        chk("t2_end_gnt_i", gnt_i, 0);
        $display("[TB] dcache-over-icache priority done");

        // dcache write burst of 8 with waitrequest toggling
        d_write = 1'b1; d_address = 32'h4000; d_burstcount = 4'd8; d_writedata = 32'h5000;
        m_waitrequest = 1'b1;
        tick();
        beat = 0; cyc = 0;
        while (beat < 8 && cyc < 40) begin
            m_waitrequest = (cyc % 2 == 0);
            d_writedata = 32'h5000 + beat;
            settle();
            chk("t3_gnt_d", gnt_d, 1);
            chk("t3_m_write", m_write, 1);
            chk("t3_m_wdata", m_writedata, 32'h5000 + beat);
            chk("t3_m_addr", m_address, 32'h4000);
            chk("t3_m_bc", m_burstcount, 8);
            chk("t3_d_wait", d_waitrequest, m_waitrequest);
            if (!m_waitrequest) beat++;
            tick();
            cyc++;
        end
        d_write = 1'b0; m_waitrequest = 1'b0;
        settle();
        chk("t3_end_m_write", m_write, 0);
        chk("t3_end_gnt_d", gnt_d, 0);
        $display("[TB] dcache write burst of 8 done");

        // Continuous dcache reads with icache waiting: fairness decides the 5th grant
        i_read = 1'b1; i_address = 32'h6000; i_burstcount = 4'd1;
        d_read = 1'b1; d_address = 32'h7000; d_burstcount = 4'd1;
        m_waitrequest = 1'b0;
        for (int g = 0; g < 5; g++) begin
            tick();
`ifdef TIGER_ARB_FAIRNESS_EN
            expD = (g < FAIR_LIMIT);
`else
            expD = 1'b1;
`endif
            chk("t4_gnt_d", gnt_d, expD);
            chk("t4_gnt_i", gnt_i, !expD);
            $display("[TB] fairness grant %0d gnt_d=%0d gnt_i=%0d", g, gnt_d, gnt_i);
            tick();
            m_readdatavalid = 1'b1; m_readdata = 32'hE000 + g;
            tick();
            m_readdatavalid = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0;
        tick();
        chk("t4_end_gnt_d", gnt_d, 0);
        chk("t4_end_gnt_i", gnt_i, 0);

        // dcache read with burstcount 0 behaves as a single beat
        d_read = 1'b1; d_address = 32'h8000; d_burstcount = 4'd0;
        tick();
        chk("t5_gnt_d", gnt_d, 1);
        chk("t5_m_bc", m_burstcount, 0);
        tick();
        d_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'hF00D;
        settle();
        chk("t5_d_rdv", d_readdatavalid, 1);
        chk("t5_d_rdata", d_readdata, 32'hF00D);
        tick();
        m_readdatavalid = 1'b0;
        settle();
        chk("t5_end_gnt_d", gnt_d, 0);
        $display("[TB] zero burstcount read done");

        // Reset in the middle of beat 2 of a 4-beat dcache read
        d_read = 1'b1; d_address = 32'h9000; d_burstcount = 4'd4;
        tick();
        tick();
        d_read = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'h1111;
        tick();
        m_readdata = 32'h2222;
        settle();
        chk("t6_beat2_d_rdv", d_readdatavalid, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_d_rdv", d_readdatavalid, 0);
        chk("t6_rst_gnt_d", gnt_d, 0);
        chk("t6_rst_d_wait", d_waitrequest, 1);
        chk("t6_rst_m_addr", m_address, 0);
        chk("t6_rst_d_rdata", d_readdata, 0);
        tick();
        reset_n = 1'b1;
        settle();
        chk("t6_stray_d_rdv", d_readdatavalid, 0);
        chk("t6_stray_i_rdv", i_readdatavalid, 0);
        tick();
        chk("t6_stray2_d_rdv", d_readdatavalid, 0);
        chk("t6_stray2_gnt_d", gnt_d, 0);
        m_readdatavalid = 1'b0;
        $display("[TB] mid-burst reset done");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
